uart_tx_port: RTL and testbench

- Memory-mapped serial output peripheral on the 8-bit CPU bus (read/write/ready handshake, same protocol as rom/ram).
- CPU writes bytes into a small FIFO; a transmitter drains the FIFO as 8N1 frames on a single output line.
- Sits beside ram in the computer address decode, gated by a select strobe from the top level. A status register lets software poll for full/empty/busy.

---
 rtl/uart_tx_port.sv | 128 ++++++++++++
 tb/tb_uart_tx_port.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - bus-mapped byte FIFO feeding an 8N1 serial transmitter
module uart_tx_port #(
    parameter int size_addr = 2,
    parameter int size      = 4,
    parameter int divisor   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel,
    input  logic       read,
    input  logic       write,
    input  logic       address,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       tx
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int baud_w = (divisor > 1) ? $clog2(divisor) : 1;
    localparam logic [baud_w-1:0]  baud_last  = baud_w'(divisor - 1);
    localparam logic [size_addr:0] count_full = (size_addr + 1)'(size);

    state_t               state, state_next;
    logic [7:0]           mem [size];
    logic [size_addr-1:0] wr_ptr, rd_ptr;
    logic [size_addr:0]   count;
    logic [baud_w-1:0]    baud_cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift;
    logic                 overflow;

    logic accept, wr_acc, rd_acc, push, drop, pop;
    logic full, empty, busy, baud_end, tx_bit;
    logic [7:0] status;

    assign full     = (count == count_full);
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign baud_end = (baud_cnt == baud_last);
    assign status   = {4'b0, overflow, busy, empty, full};

    // A held request is seen again while ready is high and must not count twice.
    assign accept = sel && (read || write) && !ready;
    assign wr_acc = accept && write;
    assign rd_acc = accept && !write;
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign push   = wr_acc && !address && (!full || pop);
    assign drop   = wr_acc && !address && !push;
    assign tx     = tx_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_bit     = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_bit = 1'b0;
                if (baud_end) state_next = DATA;
            end
            DATA: begin
                tx_bit = shift[0];
                if (baud_end && bit_cnt == 3'd7) state_next = STOP;
            end
            STOP: begin
                if (baud_end) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            overflow <= 1'b0;
            ready    <= 1'b0;
            data_out <= 8'h00;
        end else begin
            ready <= accept;
            if (rd_acc) data_out <= address ? status : 8'h00;

            if (wr_acc && address && data_in[0]) overflow <= 1'b0;
            else if (drop)                       overflow <= 1'b1;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            // Every pop happens in IDLE or on a bit boundary, so this also restarts the bit timer.
            if (state == IDLE || baud_end) baud_cnt <= '0;
            else                           baud_cnt <= baud_cnt + 1'b1;

            if (state != DATA)  bit_cnt <= '0;
            else if (baud_end)  bit_cnt <= bit_cnt + 1'b1;

            if (pop)                           shift <= mem[rd_ptr];
            else if (state == DATA && baud_end) shift <= {1'b0, shift[7:1]};
        end
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - directed scoreboard bench for uart_tx_port
module tb_uart_tx_port;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0, read = 1'b0, write = 1'b0, address = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       ready, tx;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int starts[$];
    int cyc = 0;
    bit mon_active = 1'b0;
    int mon_t = 0;
    logic [7:0] rx;

    uart_tx_port #(.size_addr(2), .size(4), .divisor(8)) dut (
        .clk(clk), .reset(rst_n), .sel(sel), .read(read), .write(write),
        .address(address), .data_in(data_in), .data_out(data_out),
        .ready(ready), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame decoder: start seen at t=0, mid-bit samples every 8 cycles after that.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_t = 0;
                starts.push_back(cyc);
            end
        end else begin
            mon_t++;
            if (mon_t == 4) check("start_bit", tx, 0);
            if (mon_t >= 12 && mon_t <= 68 && (mon_t - 12) % 8 == 0) rx[(mon_t - 12) / 8] = tx;
            if (mon_t == 76) begin
                check("stop_bit", tx, 1);
                if (exp_q.size() == 0) check("unexpected_frame", {24'h0, rx}, 32'hFFFF_FFFF);
                else                   check("frame_byte", rx, exp_q.pop_front());
                mon_active = 1'b0;
            end
        end
    end

    task automatic bus_write(input logic a, input logic [7:0] d, input bit exp_acc, input string tag);
        @(negedge clk);
        sel = 1'b1; write = 1'b1; read = 1'b0; address = a; data_in = d;
        @(posedge clk); #1;
        check({tag, "_ready1"}, ready, 1);
        sel = 1'b0; write = 1'b0;
        if (exp_acc) exp_q.push_back(d);
        @(posedge clk); #1;
        check({tag, "_ready0"}, ready, 0);
    endtask

    task automatic bus_read(input logic a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        sel = 1'b1; read = 1'b1; write = 1'b0; address = a;
        @(posedge clk); #1;
        check({tag, "_ready1"}, ready, 1);
        check({tag, "_data"}, data_out, exp);
        sel = 1'b0; read = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ready0"}, ready, 0);
        check({tag, "_hold"}, data_out, exp);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_drain_timeout"}, n < 3000, 1);
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        int nf;
        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", ready, 0);
        check("rst_data_out", data_out, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (i % 10 == 0) begin
                check("idle_tx", tx, 1);
                check("idle_ready", ready, 0);
            end
        end
        bus_read(1'b1, 8'h02, "status_reset");
        bus_read(1'b0, 8'h00, "data_reg_read");

        // Single frame 0xA5
        bus_write(1'b0, 8'hA5, 1'b1, "wr_a5");
        check("a5_start_low", tx, 0);
        bus_read(1'b1, 8'h06, "status_busy");
        drain("a5");
        bus_read(1'b1, 8'h02, "status_after_a5");

        // Five back-to-back bytes, contiguous frames
        starts.delete();
        bus_write(1'b0, 8'h11, 1'b1, "b5_0");
        bus_write(1'b0, 8'h22, 1'b1, "b5_1");
        bus_write(1'b0, 8'h33, 1'b1, "b5_2");
        bus_write(1'b0, 8'h44, 1'b1, "b5_3");
        bus_write(1'b0, 8'h55, 1'b1, "b5_4");
        bus_read(1'b1, 8'h05, "status_full");
        drain("b5");
        check("b5_frames", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++) check("b5_gap", starts[i] - starts[i-1], 80);

        // Overflow then clear
        bus_write(1'b0, 8'h61, 1'b1, "ov_0");
        bus_write(1'b0, 8'h62, 1'b1, "ov_1");
        bus_write(1'b0, 8'h63, 1'b1, "ov_2");
        bus_write(1'b0, 8'h64, 1'b1, "ov_3");
        bus_write(1'b0, 8'h65, 1'b1, "ov_4");
        bus_write(1'b0, 8'h66, 1'b0, "ov_5");
        bus_read(1'b1, 8'h0D, "status_overflow");
        bus_write(1'b1, 8'h01, 1'b0, "ov_clear");
        bus_read(1'b1, 8'h05, "status_cleared");
        drain("ov");
        bus_read(1'b1, 8'h02, "status_after_ov");

        // Held write request: exactly two accesses in four cycles
        @(negedge clk);
        sel = 1'b1; write = 1'b1; address = 1'b0; data_in = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("hold_ready", ready, (i % 2 == 0) ? 1 : 0);
        end
        sel = 1'b0; write = 1'b0;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        drain("hold");

        // Reset in the middle of the data bits
        bus_write(1'b0, 8'hF0, 1'b1, "wr_f0");
        repeat (20) @(posedge clk);
        #1;
        check("mid_data_tx_low", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_ready", ready, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        nf = starts.size();
        bus_read(1'b1, 8'h02, "status_after_rst");
        repeat (200) @(posedge clk);
        #1;
        check("no_residual_frames", starts.size(), nf);
        check("post_rst_tx", tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
